// File: rtl/reg_snapshot_dump.sv
// reg_snapshot_dump: end-of-run capture stage for the single-cycle CPU debug port.
// Waits for the committed PC to reach TRIG_PC, freezes the CPU, then streams
// PC, instruction and rf[0..31] as 34 tagged words over a valid/ready link.
// If the trigger never arrives within MAX_CYCLES idle cycles, the run ends with timeout.
module reg_snapshot_dump #(
  parameter logic [31:0] TRIG_PC    = 32'h0000_0048,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        cpu_hold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_tag,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [15:0] LAST_CYC = 16'(MAX_CYCLES - 1);
  localparam logic [5:0]  LAST_IDX = 6'd33;

  state_t      state_q;
  logic [15:0] cycCnt_q;
  logic [5:0]  idx_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [4:0]  regSel_q;
  logic        cpuHold_q;
  logic        outValid_q;
  logic        done_q;
  logic        timeout_q;

  logic [5:0]  idxNext_d;
  logic        fire;

  assign idxNext_d = idx_q + 6'd1;
  assign fire      = outValid_q && out_ready;

  // Controller: idle budget counting, trigger capture, word sequencing and the sticky end state.
  // reg_sel is loaded from the next index so the register file read is already valid
  // on the cycle the corresponding word is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cycCnt_q   <= '0;
      idx_q      <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      regSel_q   <= '0;
      cpuHold_q  <= 1'b0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cycCnt_q <= cycCnt_q + 16'd1;
          if (pc == TRIG_PC) begin
            pc_q       <= pc;
            instr_q    <= instr;
            idx_q      <= '0;
            regSel_q   <= '0;
            cpuHold_q  <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= EMIT;
          end else if (cycCnt_q == LAST_CYC) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            cpuHold_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        EMIT: begin
          if (fire) begin
            idx_q <= idxNext_d;
            if (idx_q == LAST_IDX) begin
              outValid_q <= 1'b0;
              done_q     <= 1'b1;
              regSel_q   <= '0;
              state_q    <= DONE;
            end else if (idxNext_d >= 6'd2) begin
              regSel_q <= 5'(idxNext_d - 6'd2);
            end else begin
              regSel_q <= '0;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Word mux: latched PC and instruction first, rf[0] reads as zero, the rest come live from the debug port.
  always_comb begin
    out_data = '0;
    if (outValid_q) begin
      case (idx_q)
        6'd0:    out_data = pc_q;
        6'd1:    out_data = instr_q;
        6'd2:    out_data = '0;
        default: out_data = reg_data;
      endcase
    end
  end

  assign out_tag   = outValid_q ? idx_q : 6'd0;
  assign out_valid = outValid_q;
  assign reg_sel   = regSel_q;
  assign cpu_hold  = cpuHold_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_reg_snapshot_dump.sv
// tb_reg_snapshot_dump: directed-random bench for reg_snapshot_dump.
// A behavioural register file answers reg_sel; the expected 34-word snapshot is
// built straight from the word layout (PC, instr, zero, rf[1..31]).
module tb_reg_snapshot_dump;

  localparam logic [31:0] TRIG = 32'h0000_0048;
  localparam int          MAXC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        cpu_hold;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic        done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [31:0] expWords [34];
  logic [31:0] trigInstr;
  int          nWords;

  reg_snapshot_dump #(.TRIG_PC(TRIG), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .reg_sel(reg_sel), .reg_data(reg_data), .cpu_hold(cpu_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .done(done), .timeout(timeout)
  );

  // Behavioural register file read port
  assign reg_data = rf[reg_sel];

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a loop bound is ever wrong
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nonTrigPc();
    logic [31:0] v;
    do v = $urandom(); while (v == TRIG);
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] newPc, input logic [31:0] newInstr, input logic ready);
    pc        = newPc;
    instr     = newInstr;
    out_ready = ready;
  endtask

  task automatic checkResetOutputs(input string where);
    checkOutput({where, ".valid"},   32'(out_valid), 32'd0);
    checkOutput({where, ".hold"},    32'(cpu_hold),  32'd0);
    checkOutput({where, ".data"},    out_data,       32'd0);
    checkOutput({where, ".tag"},     32'(out_tag),   32'd0);
    checkOutput({where, ".regSel"},  32'(reg_sel),   32'd0);
    checkOutput({where, ".done"},    32'(done),      32'd0);
    checkOutput({where, ".timeout"}, 32'(timeout),   32'd0);
  endtask

  task automatic doReset();
    applyStimulus(nonTrigPc(), $urandom(), 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checkResetOutputs("reset");
    rst = 1'b0;
  endtask

  // Fill the register file and derive the snapshot the consumer should receive
  task automatic loadModel(input logic dead);
    for (int i = 0; i < 32; i++) rf[i] = dead ? 32'hDEAD_BEEF : $urandom();
    if (!dead) rf[7] = 32'h0000_0007;
    trigInstr   = $urandom();
    expWords[0] = TRIG;
    expWords[1] = trigInstr;
    expWords[2] = 32'h0;
    for (int k = 3; k < 34; k++) expWords[k] = rf[k - 2];
  endtask

  // Present the trigger PC and check the stage takes over on the next cycle
  task automatic fireTrigger(input logic ready);
    applyStimulus(TRIG, trigInstr, ready);
    tick();
    checkOutput("trig.valid",  32'(out_valid), 32'd1);
    checkOutput("trig.hold",   32'(cpu_hold),  32'd1);
    checkOutput("trig.tag",    32'(out_tag),   32'd0);
    checkOutput("trig.timeout", 32'(timeout),  32'd0);
  endtask

  // Drain the stream; mode 0 ready high, 1 ready pattern 1-0-0-1, 2 random ready.
  // abortTag >= 0 pulses reset while that word is presented.
  task automatic runDump(input int mode, input int abortTag, output int count);
    int          cyc = 0;
    int          phase = 0;
    logic        stalled = 1'b0;
    logic [5:0]  lastTag = '0;
    logic [31:0] lastData = '0;
    logic        rdy;
    count = 0;
    while (count < 34 && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((phase % 4) == 0) || ((phase % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      applyStimulus(($urandom_range(0, 3) == 0) ? TRIG : nonTrigPc(), $urandom(), rdy);
      checkOutput("emit.valid", 32'(out_valid), 32'd1);
      checkOutput("emit.hold",  32'(cpu_hold),  32'd1);
      if (stalled) begin
        checkOutput("stall.tag",  32'(out_tag), 32'(lastTag));
        checkOutput("stall.data", out_data,     lastData);
      end
      checkOutput("word.tag",  32'(out_tag), 32'(count));
      checkOutput("word.data", out_data,     expWords[count]);
      if (count >= 2) checkOutput("word.regSel", 32'(reg_sel), 32'(count - 2));
      if (count == abortTag) begin
        rst = 1'b1;
        tick();
        checkResetOutputs("midReset");
        rst = 1'b0;
        return;
      end
      if (rdy) begin
        count++;
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        lastTag  = out_tag;
        lastData = out_data;
      end
      tick();
      cyc++;
    end
    checkOutput("dump.count",   32'(count),     32'd34);
    checkOutput("end.done",     32'(done),      32'd1);
    checkOutput("end.valid",    32'(out_valid), 32'd0);
    checkOutput("end.timeout",  32'(timeout),   32'd0);
    checkOutput("end.hold",     32'(cpu_hold),  32'd1);
  endtask

  // After the run ends, a trigger PC and ready must change nothing
  task automatic checkStaysDone(input logic expTimeout);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(TRIG, $urandom(), 1'b1);
      tick();
      checkOutput("post.valid",   32'(out_valid), 32'd0);
      checkOutput("post.done",    32'(done),      32'd1);
      checkOutput("post.timeout", 32'(timeout),   32'(expTimeout));
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Trigger with ready held high: exactly 34 words, done on the 35th cycle
    doReset();
    loadModel(1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(nonTrigPc(), $urandom(), 1'b1);
      tick();
      checkOutput("idle.valid", 32'(out_valid), 32'd0);
      checkOutput("idle.tag",   32'(out_tag),   32'd0);
    end
    fireTrigger(1'b1);
    runDump(0, -1, nWords);
    checkStaysDone(1'b0);

    // Backpressure with ready 1-0-0-1 and rf[0] reading nonzero on the port
    doReset();
    loadModel(1'b1);
    tick();
    fireTrigger(1'b1);
    runDump(1, -1, nWords);
    checkStaysDone(1'b0);

    // Timeout: no trigger, done and timeout appear MAXC cycles after reset release
    doReset();
    for (int k = 1; k < MAXC; k++) begin
      applyStimulus(nonTrigPc(), $urandom(), 1'b1);
      tick();
      checkOutput("budget.done",  32'(done),      32'd0);
      checkOutput("budget.valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(nonTrigPc(), $urandom(), 1'b1);
    tick();
    checkOutput("timeout.done",    32'(done),      32'd1);
    checkOutput("timeout.timeout", 32'(timeout),   32'd1);
    checkOutput("timeout.hold",    32'(cpu_hold),  32'd1);
    checkOutput("timeout.valid",   32'(out_valid), 32'd0);
    checkStaysDone(1'b1);

    // Trigger on the very cycle the budget expires: trigger wins
    doReset();
    loadModel(1'b0);
    for (int k = 1; k < MAXC; k++) begin
      applyStimulus(nonTrigPc(), $urandom(), 1'b0);
      tick();
    end
    checkOutput("edge.done", 32'(done), 32'd0);
    fireTrigger(1'b0);
    runDump(2, -1, nWords);
    checkStaysDone(1'b0);

    // Reset while word 10 is presented, then a fresh complete dump
    doReset();
    loadModel(1'b0);
    tick();
    fireTrigger(1'b1);
    runDump(2, 10, nWords);
    applyStimulus(nonTrigPc(), $urandom(), 1'b0);
    tick();
    checkOutput("reidle.valid", 32'(out_valid), 32'd0);
    checkOutput("reidle.hold",  32'(cpu_hold),  32'd0);
    loadModel(1'b0);
    fireTrigger(1'b1);
    runDump(0, -1, nWords);
    checkStaysDone(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_snapshot_dump.md
# reg_snapshot_dump

Synthesizable end-of-run capture stage placed directly downstream of the single-cycle computer's debug port (`pc`, `instr`, `reg_sel`/`reg_data`). It watches the committed PC for a trigger address, freezes the CPU, walks all 32 architectural registers through the `reg_sel`/`reg_data` port, and streams a 34-word snapshot (PC, instruction, rf[0..31]) over a valid/ready interface. A cycle budget ends the run with a timeout flag if the trigger PC is never reached.

## Interface
Parameters:
- `TRIG_PC`, 32'h0000_0048: PC value that triggers the snapshot.
- `MAX_CYCLES`, 1000: idle-cycle budget before timeout; legal range 1..2^16-1.

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `pc`  in  32  current PC from the CPU.
- `instr`  in  32  instruction at `pc`.
- `reg_sel`  out  5  register index driven to the CPU debug port.
- `reg_data`  in  32  combinational register-file read of `reg_sel`.
- `cpu_hold`  out  1  freezes CPU state (PC and register-file writes) while high.
- `out_valid`  out  1  snapshot word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  32  snapshot word.
- `out_tag`  out  6  word index 0..33.
- `done`  out  1  sticky: run finished (dump complete or timeout).
- `timeout`  out  1  sticky: run ended by cycle budget without trigger.

## Operation
- States: IDLE, EMIT, DONE. Reset enters IDLE.
- IDLE: 16-bit `cyc_cnt` increments every cycle. If `pc == TRIG_PC`, latch `pc_q <= pc` and `instr_q <= instr`, set `idx <= 0`, go to EMIT. Otherwise, if `cyc_cnt == MAX_CYCLES-1`, set `timeout <= 1` and go to DONE.
- Trigger and budget expiry in the same cycle: trigger wins; `timeout` stays 0.
- EMIT: `out_valid = 1`, `out_tag = idx`. `out_data` = `pc_q` when idx=0, `instr_q` when idx=1, otherwise `reg_data` with `reg_sel = idx-2`. Word 2 (rf[0]) is forced to 32'h0 regardless of `reg_data`.
- Transfer occurs on a cycle with `out_valid && out_ready`; then `idx <= idx+1`. Transfer at idx=33 goes to DONE.
- When idx ≤ 1, `reg_sel` holds 0. It is registered from next-`idx` so that it equals idx-2 on the same cycle word idx is presented.
- DONE: `done = 1`, `out_valid = 0`, `cpu_hold = 1`. Exits only on `rst`.
- `cpu_hold` = 1 in EMIT and DONE, 0 in IDLE. The CPU state is therefore frozen from the cycle after the trigger.

## Timing
- Reset values: `reg_sel`=0, `cpu_hold`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `done`=0, `timeout`=0. Internal `cyc_cnt`=0 and `idx`=0.
- Trigger latency: the trigger is sampled at edge N. `out_valid` and `cpu_hold` are high from cycle N+1.
- With `out_ready` held high, the dump takes exactly 34 cycles (N+1..N+34). `done` rises at N+35.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_tag`, and `reg_sel` hold stable. No word is skipped or duplicated.
- `out_ready` asserted outside EMIT is ignored.
- Timeout: with no trigger, `done` and `timeout` rise on the cycle after `cyc_cnt` reaches `MAX_CYCLES-1`, i.e. MAX_CYCLES cycles after reset release.
- `rst` asserted mid-EMIT: next cycle all outputs return to reset values, state goes to IDLE, and the partial dump is abandoned.
- `pc == TRIG_PC` seen in EMIT or DONE: ignored, no re-trigger.

## Test plan
- Trigger, ready high: CPU program reaches pc=0x48 with rf[7]=0x0000_0007. Expect a 34-word stream with tag0=0x48, tag1=`instr`, tag2=0, tag9=0x7. `done`=1 at trigger+35 and `timeout`=0.
- Backpressure: toggle `out_ready` 1-0-0-1 repeatedly during EMIT. Expect exactly 34 transfers, tags 0..33 in order, with data stable across stall cycles.
- Timeout: PC never equals TRIG_PC and MAX_CYCLES=20. Expect `done`=`timeout`=1 on cycle 20 after reset, `out_valid` never high, and `cpu_hold`=1 from that cycle.
- Simultaneous: force `pc`=TRIG_PC on cycle MAX_CYCLES-1. Expect EMIT entered, `timeout`=0, and the full dump.
- Reset mid-dump: assert `rst` one cycle at tag 10. Expect the next cycle to have all outputs 0 and state IDLE. A later trigger then produces a complete dump starting at tag 0.
- rf[0] forcing: drive `reg_data`=0xDEAD_BEEF for all selects. Expect tag2=0 and tags 3..33=0xDEAD_BEEF, with `reg_sel` equal to tag-2.
